// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the RAM data-port arbiter: default wait bound,
// read-owner tag encodings and grant selector.
package mem_port_arb_pkg;

   localparam int MAX_WAIT_DEF = 8;
   localparam int SCNT_W_DEF   = 16;
   localparam int WAIT_W       = 8;

   localparam logic [3:0] WREN_NONE = 4'b0000;
   localparam logic [3:0] WREN_WORD = 4'b1111;

   // Owner of the read issued in the previous cycle; steers host_rvalid.
   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_CPU  = 2'd1,
      RD_HOST = 2'd2
   } rd_owner_e;

   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_HOST = 2'd2
   } gnt_sel_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_port_arb_wait_cnt.sv
// Saturating host-wait counter; force_o flags that the host has waited
// MAX_WAIT cycles and must take the next slot.
module arb_wait_cnt
   import mem_port_arb_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic force_o
);

   localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] cnt_q;
   logic [WAIT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_WAIT_W)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_o = (cnt_q == MAX_WAIT_W);

endmodule

// File: rtl/mem_port_arb.sv
// CPU/host arbiter for the shared RAM data port with a bounded host wait.
// Optional MEM_ARB_HALT_EN adds host_halt, giving the host the port outright.
module mem_port_arb
   import mem_port_arb_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int SCNT_W   = SCNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [3:0]        cpu_wr_en,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [31:0]       host_addr,
   input  logic [31:0]       host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [31:0]       host_rdata,
`ifdef MEM_ARB_HALT_EN
   input  logic              host_halt,
`endif
   output logic [31:0]       mem_addr,
   output logic [3:0]        mem_wren,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout,
   output logic [SCNT_W-1:0] stall_cnt
);

   logic              halt;
   logic              wait_force;
   logic              host_force;
   logic              wait_clr;
   gnt_sel_e          sel;
   rd_owner_e         rd_owner_q;
   rd_owner_e         rd_owner_d;
   logic [SCNT_W-1:0] stall_cnt_q;
   logic [SCNT_W-1:0] stall_cnt_d;

`ifdef MEM_ARB_HALT_EN
   assign halt = host_halt;
`else
   assign halt = 1'b0;
`endif

   assign host_force = host_req && wait_force;
   // Halt also pins the wait counter so release resumes with a fresh bound.
   assign wait_clr   = host_gnt || !host_req || halt;

   arb_wait_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (wait_clr),
      .inc_i   (1'b1),
      .force_o (wait_force)
   );

   always_comb begin
      sel        = GNT_IDLE;
      cpu_stall  = 1'b0;
      host_gnt   = 1'b0;
      mem_addr   = '0;
      mem_wren   = WREN_NONE;
      mem_din    = '0;
      rd_owner_d = RD_NONE;
      if (rst) begin
         if (halt) begin
            sel = host_req ? GNT_HOST : GNT_IDLE;
         end else if (host_force) begin
            sel = GNT_HOST;
         end else if (cpu_req) begin
            sel = GNT_CPU;
         end else if (host_req) begin
            sel = GNT_HOST;
         end
         cpu_stall = cpu_req && (halt || host_force);
         case (sel)
            GNT_CPU: begin
               mem_addr   = cpu_addr;
               mem_wren   = cpu_wr_en;
               mem_din    = cpu_wdata;
               rd_owner_d = (cpu_wr_en == WREN_NONE) ? RD_CPU : RD_NONE;
            end
            GNT_HOST: begin
               host_gnt   = 1'b1;
               mem_addr   = word_align(host_addr);
               mem_wren   = host_we ? WREN_WORD : WREN_NONE;
               mem_din    = host_wdata;
               rd_owner_d = host_we ? RD_NONE : RD_HOST;
            end
            default: begin
               mem_wren = WREN_NONE;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cpu_stall && (stall_cnt_q != {SCNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_owner_q  <= RD_NONE;
         stall_cnt_q <= '0;
      end else begin
         rd_owner_q  <= rd_owner_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // The RAM output is registered, so both requesters see it directly.
   assign host_rvalid = (rd_owner_q == RD_HOST);
   assign host_rdata  = mem_dout;
   assign cpu_rdata   = mem_dout;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb with a behavioural RAM and a read scoreboard.
// Define MEM_ARB_HALT_EN to also exercise the host_halt path.
module tb_mem_port_arb;
   import mem_port_arb_pkg::*;

   localparam int MAX_WAIT = 8;
   localparam int SCNT_W   = 16;

   logic              clk;
   logic              rst;
   logic              cpu_req;
   logic [3:0]        cpu_wr_en;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_stall;
   logic              host_req;
   logic              host_we;
   logic [31:0]       host_addr;
   logic [31:0]       host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [31:0]       host_rdata;
   logic              host_halt;
   logic [31:0]       mem_addr;
   logic [3:0]        mem_wren;
   logic [31:0]       mem_din;
   logic [31:0]       mem_dout;
   logic [SCNT_W-1:0] stall_cnt;

   mem_port_arb #(
      .MAX_WAIT (MAX_WAIT),
      .SCNT_W   (SCNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_wr_en   (cpu_wr_en),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
`ifdef MEM_ARB_HALT_EN
      .host_halt   (host_halt),
`endif
      .mem_addr    (mem_addr),
      .mem_wren    (mem_wren),
      .mem_din     (mem_din),
      .mem_dout    (mem_dout),
      .stall_cnt   (stall_cnt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: byte-enabled write, registered read
   logic [31:0] ram [0:255];
   logic        ram_fill;

   function automatic logic [31:0] init_word(input int i);
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   always @(posedge clk) begin
      if (ram_fill) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wren[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_din[b*8 +: 8];
         end
      end
      mem_dout <= ram[mem_addr[9:2]];
   end

   // scoreboard and reference state
   logic [31:0]       shadow [0:255];
   logic [31:0]       host_exp_q [$];
   logic [31:0]       cpu_exp_q [$];
   int                m_wait;
   logic [SCNT_W-1:0] m_scnt;
   logic              m_halt;
   logic              exp_rv;
   logic              exp_cv;
   logic              m_last_hgnt;
   logic              last_gnt;
   logic              last_stall;
   int                total;
   int                bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_wait = 0;
      m_scnt = '0;
      exp_rv = 1'b0;
      exp_cv = 1'b0;
      host_exp_q.delete();
      cpu_exp_q.delete();
   endtask

   // One clock of stimulus plus full output prediction for that cycle.
   task automatic step(input logic c_req, input logic [3:0] c_we, input logic [31:0] c_addr,
                       input logic [31:0] c_wd, input logic h_req, input logic h_we,
                       input logic [31:0] h_addr, input logic [31:0] h_wd);
      logic m_hgnt;
      logic m_cgnt;
      logic m_stall;
      logic [7:0] w;
      @(negedge clk);
      cpu_req    = c_req;
      cpu_wr_en  = c_we;
      cpu_addr   = c_addr;
      cpu_wdata  = c_wd;
      host_req   = h_req;
      host_we    = h_we;
      host_addr  = h_addr;
      host_wdata = h_wd;
      host_halt  = m_halt;
      #2;
      check("host_rvalid", 32'(host_rvalid), 32'(exp_rv));
      if (exp_rv) begin
         if (host_exp_q.size() == 0) check("host_q_underrun", 32'd1, 32'd0);
         else check("host_rdata", host_rdata, host_exp_q.pop_front());
      end
      if (exp_cv) begin
         if (cpu_exp_q.size() == 0) check("cpu_q_underrun", 32'd1, 32'd0);
         else check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
      end
      check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      if (m_halt) begin
         m_hgnt  = h_req;
         m_cgnt  = 1'b0;
         m_stall = c_req;
      end else begin
         m_hgnt  = h_req && ((m_wait == MAX_WAIT) || !c_req);
         m_cgnt  = c_req && !m_hgnt;
         m_stall = c_req && m_hgnt;
      end
      check("host_gnt", 32'(host_gnt), 32'(m_hgnt));
      check("cpu_stall", 32'(cpu_stall), 32'(m_stall));
      if (m_hgnt) begin
         w = h_addr[9:2];
         check("mem_addr_h", mem_addr, {h_addr[31:2], 2'b00});
         check("mem_wren_h", 32'(mem_wren), h_we ? 32'hF : 32'h0);
         if (h_we) begin
            check("mem_din_h", mem_din, h_wd);
            shadow[w] = h_wd;
         end else begin
            host_exp_q.push_back(shadow[w]);
         end
      end else if (m_cgnt) begin
         w = c_addr[9:2];
         check("mem_addr_c", mem_addr, c_addr);
         check("mem_wren_c", 32'(mem_wren), 32'(c_we));
         if (c_we != 4'b0000) begin
            check("mem_din_c", mem_din, c_wd);
            for (int b = 0; b < 4; b++) if (c_we[b]) shadow[w][b*8 +: 8] = c_wd[b*8 +: 8];
         end else begin
            cpu_exp_q.push_back(shadow[w]);
         end
      end else begin
         check("mem_wren_idle", 32'(mem_wren), 32'h0);
      end
      exp_rv = m_hgnt && !h_we;
      exp_cv = m_cgnt && (c_we == 4'b0000);
      if (m_halt || !h_req || m_hgnt) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (m_stall && (m_scnt != {SCNT_W{1'b1}})) m_scnt = m_scnt + 1'b1;
      m_last_hgnt = m_hgnt;
      last_gnt    = host_gnt;
      last_stall  = cpu_stall;
   endtask

   task automatic idle();
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"}, 32'(host_gnt), 32'h0);
      check({tag, "_stall"}, 32'(cpu_stall), 32'h0);
      check({tag, "_rvalid"}, 32'(host_rvalid), 32'h0);
      check({tag, "_wren"}, 32'(mem_wren), 32'h0);
      check({tag, "_addr"}, mem_addr, 32'h0);
      check({tag, "_din"}, mem_din, 32'h0);
      check({tag, "_scnt"}, 32'(stall_cnt), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      int gnt_cyc;
      int gnts;
      int prev;
      logic       h_pend;
      logic       h_we_r;
      logic [31:0] h_addr_r;
      logic [31:0] h_wd_r;
      logic [3:0]  we_tab [4];

      total = 0;
      bad   = 0;
      m_halt = 1'b0;
      m_last_hgnt = 1'b0;
      model_clear();
      for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
      we_tab[0] = 4'b0000;
      we_tab[1] = 4'b1111;
      we_tab[2] = 4'b0011;
      we_tab[3] = 4'b1100;

      // reset with both requesters active
      rst = 1'b0; ram_fill = 1'b1; host_halt = 1'b0;
      cpu_req = 1'b1; cpu_wr_en = 4'hF; cpu_addr = 32'h104; cpu_wdata = 32'h5555_AAAA;
      host_req = 1'b1; host_we = 1'b1; host_addr = 32'h48; host_wdata = 32'h1234_5678;
      repeat (3) @(negedge clk);
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      ram_fill = 1'b0;
      cpu_req = 1'b0; host_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // CPU only, alternating read / half-word write to 0x100
      stalls = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, (i % 2 == 1) ? 4'b0011 : 4'b0000, 32'h100, 32'h7700_0000 + 32'(i),
              1'b0, 1'b0, 32'h0, 32'h0);
         if (last_stall) stalls++;
      end
      idle();
      check("cpu_only_stalls", 32'(stalls), 32'd0);
      check("cpu_only_scnt", 32'(stall_cnt), 32'd0);

      // host read in an idle slot
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
      check("idle_gnt", 32'(last_gnt), 32'd1);
      idle();
      check("idle_rvalid", 32'(host_rvalid), 32'd1);
      check("idle_rdata", host_rdata, init_word(16));

      // starvation bound: host write under continuous CPU traffic
      stalls = 0;
      gnt_cyc = 0;
      for (int c = 1; c <= 12 && gnt_cyc == 0; c++) begin
         step(1'b1, (c % 2 == 1) ? 4'b0000 : 4'b0001, 32'h104, 32'h0000_00C0 + 32'(c),
              1'b1, 1'b1, 32'h80, 32'hDEADBEEF);
         if (last_gnt) gnt_cyc = c;
         if (last_stall) stalls++;
      end
      idle();
      check("starve_gnt_cycle", 32'(gnt_cyc), 32'd9);
      check("starve_stalls", 32'(stalls), 32'd1);
      check("starve_scnt", 32'(stall_cnt), 32'd1);
      check("starve_ram", ram[32], 32'hDEADBEEF);

      // four back-to-back host reads under contention
      gnts = 0;
      prev = 0;
      for (int c = 1; c <= 60 && gnts < 4; c++) begin
         step(1'b1, 4'b0000, 32'h108, 32'h0, 1'b1, 1'b0, 32'h20 + 32'(gnts * 4), 32'h0);
         if (last_gnt) begin
            gnts++;
            check("b2b_interval", 32'(c - prev), 32'd9);
            prev = c;
         end
      end
      idle();
      check("b2b_grants", 32'(gnts), 32'd4);
      check("b2b_scnt", 32'(stall_cnt), 32'd5);

      // read back the forced write
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h83, 32'h0);
      idle();
      check("readback_80", host_rdata, 32'hDEADBEEF);

`ifdef MEM_ARB_HALT_EN
      // halt: host owns the port, CPU stalled every cycle
      m_halt = 1'b1;
      stalls = 0;
      gnts = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 4'b0000, 32'h100, 32'h0, 1'b1, 1'b0, 32'h40 + 32'(i * 4), 32'h0);
         if (last_gnt) gnts++;
         if (last_stall) stalls++;
      end
      m_halt = 1'b0;
      step(1'b1, 4'b0000, 32'h100, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0);
      check("halt_release_stall", 32'(last_stall), 32'd0);
      check("halt_stalls", 32'(stalls), 32'd10);
      check("halt_gnts", 32'(gnts), 32'd10);
      check("halt_scnt", 32'(stall_cnt), 32'd15);
      idle();
`endif

      // random traffic; host request held until the reference grant
      h_pend = 1'b0; h_we_r = 1'b0; h_addr_r = '0; h_wd_r = '0;
      for (int c = 0; c < 200; c++) begin
         if (!h_pend && ($urandom_range(0, 2) == 0)) begin
            h_pend   = 1'b1;
            h_we_r   = 1'($urandom_range(0, 1));
            h_addr_r = 32'($urandom_range(0, 1023));
            h_wd_r   = $urandom;
         end
         step(1'($urandom_range(0, 3) != 0), we_tab[$urandom_range(0, 3)],
              {22'b0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
              h_pend, h_we_r, h_addr_r, h_wd_r);
         if (m_last_hgnt) h_pend = 1'b0;
      end
      idle();

      // reset in the cycle after a host read grant
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      check("rst_pre_gnt", 32'(last_gnt), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      cpu_req = 1'b1; cpu_wr_en = 4'hF; cpu_addr = 32'h10C; cpu_wdata = 32'hCAFE_F00D;
      host_req = 1'b1; host_we = 1'b0;
      #2;
      check_reset_outputs("midrst");
      @(negedge clk);
      #2;
      check_reset_outputs("midrst_hold");
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      cpu_req = 1'b0;
      host_req = 1'b0;
      step(1'b1, 4'hF, 32'h10C, 32'h1357_9BDF, 1'b0, 1'b0, 32'h0, 32'h0);
      check("post_rst_stall", 32'(last_stall), 32'd0);
      check("post_rst_wren", 32'(mem_wren), 32'hF);
      idle();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
